// File: rtl/multiword_adder_ctrl_pkg.sv
// Shared definitions for the multi-word adder sequencer.
//   - FSM state encoding (2-bit, legacy-compatible constants)
//   - clog2 helper used to size the word counter
package adder_ctrl_pkg;

   typedef logic [1:0] state_t;

   // 2'd3 is unused; the controller recovers from it to S_IDLE.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (v > 0) ? v - 1 : 0;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/multiword_adder_ctrl_if.sv
// Requester-side bus of the multi-word adder sequencer.
//   start, sub, ci : request, operation select, carry-in (requester -> controller)
//   a, b           : N*W-bit operands (requester -> controller)
//   busy, done     : status; done is a one-cycle result-valid pulse
//   sum, cout, ovf : registered result, carry out of MSW, signed overflow
// master = requester, slave = controller.
interface multiword_adder_ctrl_if #(
   parameter int N = 4,
   parameter int W = 4
);

   logic             start;
   logic             sub;
   logic             ci;
   logic [N*W-1:0]   a;
   logic [N*W-1:0]   b;
   logic             busy;
   logic             done;
   logic [N*W-1:0]   sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, ci, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, ci, a, b,
      output busy, done, sum, cout, ovf
   );

endinterface

// File: rtl/multiword_adder_ctrl_adder.sv
// N-bit combinational adder datapath shared by the sequencer.
//   a, b : N-bit addends
//   ci   : carry in
//   sum  : N-bit sum
//   cout : carry out
module full_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = (N+1)'(a) + (N+1)'(b) + (N+1)'(ci);

endmodule

// File: rtl/multiword_adder_ctrl.sv
// Sequencer that adds or subtracts two N*W-bit operands one N-bit word per
// clock through a single shared full_adder, carry chained LSW to MSW.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of multiword_adder_ctrl_if
//         (start/sub/ci/a/b in; busy/done/sum/cout/ovf out, all registered)
module multiword_adder_ctrl
   import adder_ctrl_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   multiword_adder_ctrl_if.slave  bus
);

   localparam int NW = N * W;
   localparam int KW = (clog2(W) > 0) ? clog2(W) : 1;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic            c_q, c_d;
   logic [NW-1:0]   a_q, a_d;
   logic [NW-1:0]   b_q, b_d;
   logic            sub_q, sub_d;
   logic [NW-1:0]   sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [N-1:0]    add_a, add_b, add_sum;
   logic            add_ci, add_cout;
   logic            last_word;

   full_adder #(.N(N)) u_adder (
      .a    (add_a),
      .b    (add_b),
      .ci   (add_ci),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign last_word = (k_q == KW'(W - 1));

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      c_d     = c_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      add_a   = '0;
      add_b   = '0;
      add_ci  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               a_d     = bus.a;
               // Subtraction is a + ~b + 1: invert B here, seed the carry with 1.
               b_d     = bus.sub ? ~bus.b : bus.b;
               c_d     = bus.sub | bus.ci;
               k_d     = '0;
               sub_d   = bus.sub;
               busy_d  = 1'b1;
            end
         end

         S_RUN: begin
            add_a  = a_q[N-1:0];
            add_b  = b_q[N-1:0];
            add_ci = c_q;
            for (int unsigned j = 0; j < W; j++) begin
               if (KW'(j) == k_q) sum_d[j*N +: N] = add_sum;
            end
            c_d = add_cout;
            a_d = a_q >> N;
            b_d = b_q >> N;
            k_d = k_q + 1'b1;
            if (last_word) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cout_d  = add_cout;
               // Low word of A/B now holds the MSW; B is already inverted for sub.
               ovf_d   = (a_q[N-1] == b_q[N-1]) && (add_sum[N-1] != a_q[N-1]);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         c_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         c_q     <= c_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // A subtraction must enter its first word with the +1 carry seeded.
   a_sub_carry_seed: assert property (@(posedge clk) disable iff (rst)
      (state_q == S_RUN && k_q == '0 && sub_q) |-> c_q);

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

endmodule
